// File: rtl/chacha_pkg.sv
// Shared constants and types for the ChaCha keystream consumer.
// Block width, default word width and request FSM encoding.
package chacha_pkg;

   localparam int CHACHA_BLK_W = 512;
   localparam int DATA_W_DEF   = 128;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   function automatic int segs_of(input int dw);
      return CHACHA_BLK_W / dw;
   endfunction

endpackage

// File: rtl/chacha_stream_xor_if.sv
// Stream and keystream handshake bundle for chacha_stream_xor.
// The slave side is the XOR block; master is its environment.
interface chacha_stream_xor_if
   import chacha_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);

   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_W-1:0]       in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_W-1:0]       out_data;
   logic                    out_last;
   logic                    ks_req;
   logic                    ks_valid;
   logic [CHACHA_BLK_W-1:0] ks_data;

   modport master (
      output in_valid, in_data, in_last,
      output out_ready,
      output ks_valid, ks_data,
      input  in_ready,
      input  out_valid, out_data, out_last,
      input  ks_req
   );

   modport slave (
      input  in_valid, in_data, in_last,
      input  out_ready,
      input  ks_valid, ks_data,
      output in_ready,
      output out_valid, out_data, out_last,
      output ks_req
   );

endinterface

// File: rtl/chacha_ks_buffer.sv
// Two-entry FIFO of keystream blocks with push, pop and flush.
// Flush wins over a same-cycle push so a late block never outlives its message.
module chacha_ks_buffer
   import chacha_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [CHACHA_BLK_W-1:0] wdata,
   output logic [CHACHA_BLK_W-1:0] head,
   output logic [1:0]              count
);

   logic [CHACHA_BLK_W-1:0] mem_q [2];
   logic [CHACHA_BLK_W-1:0] mem_d [2];
   logic                    wr_ptr_q, wr_ptr_d;
   logic                    rd_ptr_q, rd_ptr_d;
   logic [1:0]              cnt_q, cnt_d;
   logic                    do_push, do_pop;

   always_comb begin
      do_pop   = pop && (cnt_q != 2'd0);
      do_push  = push && ((cnt_q != 2'd2) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_d = ~rd_ptr_q;
         cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = cnt_q;

endmodule

// File: rtl/chacha_stream_xor.sv
// Keystream consumer: prefetches ChaCha blocks and XORs them,
// segment by segment, onto a valid/ready message stream.
module chacha_stream_xor
   import chacha_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int KS_TIMEOUT = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   chacha_stream_xor_if.slave  io,
   output logic                busy,
   output logic [31:0]         blk_count,
   output logic                ks_timeout,
   output logic                ks_unexp
);

   localparam int SEGS = segs_of(DATA_W);
   localparam int SW   = $clog2(SEGS);
   localparam int CW   = $clog2(KS_TIMEOUT + 1);
   localparam logic [CW-1:0] KS_LIM = CW'(KS_TIMEOUT);

   state_e              state_q, state_d;
   logic                active_q, active_d;
   logic                drop_q, drop_d;
   logic [SW-1:0]       seg_idx_q, seg_idx_d;
   logic [31:0]         blk_count_q, blk_count_d;
   logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic                timeout_q, timeout_d;
   logic                unexp_q, unexp_d;

   logic [CHACHA_BLK_W-1:0] head;
   logic [1:0]              buf_cnt;
   logic [DATA_W-1:0]       seg;
   logic in_rdy, acc, last_acc, seg_end, pop;
   logic start_acc, flush, req_ok;
   logic ks_req, fill, unexp_ev;

   assign busy      = active_q | (state_q == S_WAIT) | out_valid_q;
   assign start_acc = start & ~busy;
   assign in_rdy    = active_q & (buf_cnt != 2'd0)
                    & (~out_valid_q | io.out_ready);
   assign acc       = io.in_valid & in_rdy;
   assign last_acc  = acc & io.in_last;
   assign seg_end   = seg_idx_q == SW'(SEGS - 1);
   assign pop       = acc & (seg_end | io.in_last);
   assign flush     = start_acc | last_acc;
   // No new request on the closing beat: its block could never be used.
   assign req_ok    = active_q & ~last_acc & (buf_cnt != 2'd2);

   always_comb begin
      seg = '0;
      for (int k = 0; k < SEGS; k++) begin
         if (seg_idx_q == SW'(k)) seg = head[DATA_W*k +: DATA_W];
      end
   end

   chacha_ks_buffer u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (fill),
      .pop   (pop),
      .flush (flush),
      .wdata (io.ks_data),
      .head  (head),
      .count (buf_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (req_ok) state_d = S_WAIT;
         S_WAIT: if (io.ks_valid) state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ks_req   = (state_q == S_IDLE) & req_ok;
      fill     = (state_q == S_WAIT) & io.ks_valid & ~drop_q & ~flush;
      unexp_ev = (state_q == S_IDLE) & io.ks_valid;
   end

   always_comb begin
      active_d    = active_q;
      drop_d      = drop_q;
      seg_idx_d   = seg_idx_q;
      blk_count_d = blk_count_q;
      wait_cnt_d  = wait_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      timeout_d   = timeout_q;
      unexp_d     = unexp_q;
      if (start_acc)     active_d = 1'b1;
      else if (last_acc) active_d = 1'b0;
      if (flush)         seg_idx_d = '0;
      else if (acc)      seg_idx_d = seg_end ? '0 : seg_idx_q + 1'b1;
      if (start_acc)     blk_count_d = '0;
      else if (pop)      blk_count_d = blk_count_q + 32'd1;
      if (state_q == S_WAIT && io.ks_valid) drop_d = 1'b0;
      else if (state_q == S_WAIT && last_acc) drop_d = 1'b1;
      if (ks_req) wait_cnt_d = '0;
      else if (state_q == S_WAIT && wait_cnt_q != KS_LIM)
         wait_cnt_d = wait_cnt_q + 1'b1;
      if (acc) begin
         out_valid_d = 1'b1;
         out_data_d  = io.in_data ^ seg;
         out_last_d  = io.in_last;
      end else if (io.out_ready) begin
         out_valid_d = 1'b0;
      end
      if (start_acc) begin
         timeout_d = 1'b0;
         unexp_d   = 1'b0;
      end else begin
         timeout_d = timeout_q
                   | ((state_q == S_WAIT) && (wait_cnt_q == KS_LIM));
         unexp_d   = unexp_q | unexp_ev;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q    <= 1'b0;
         drop_q      <= 1'b0;
         seg_idx_q   <= '0;
         blk_count_q <= '0;
         wait_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         timeout_q   <= 1'b0;
         unexp_q     <= 1'b0;
      end else begin
         active_q    <= active_d;
         drop_q      <= drop_d;
         seg_idx_q   <= seg_idx_d;
         blk_count_q <= blk_count_d;
         wait_cnt_q  <= wait_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         timeout_q   <= timeout_d;
         unexp_q     <= unexp_d;
      end
   end

   assign io.in_ready  = in_rdy;
   assign io.out_valid = out_valid_q;
   assign io.out_data  = out_data_q;
   assign io.out_last  = out_last_q;
   assign io.ks_req    = ks_req;
   assign blk_count    = blk_count_q;
   assign ks_timeout   = timeout_q;
   assign ks_unexp     = unexp_q;

endmodule
